// File: rtl/biriscv_v_issue_pkg.sv
// -----------------------------------------------------------------------------
// biriscv_v_issue_pkg
// Shared definitions for the vector issue block: match/mask constants for the
// supported OP-V integer instructions, instruction field positions, the
// buffered-instruction record and a decode helper.
// -----------------------------------------------------------------------------
package biriscv_v_issue_pkg;

    // Every supported instruction is identified by funct6, funct3 and major
    // opcode, so one mask covers the whole set.
    localparam logic [31:0] INST_V_MASK    = 32'hfc00707f;

    localparam logic [31:0] INST_VADD_VV   = 32'h00000057;
    localparam logic [31:0] INST_VADD_VX   = 32'h00004057;
    localparam logic [31:0] INST_VADD_VI   = 32'h00003057;
    localparam logic [31:0] INST_VSUB_VV   = 32'h08000057;
    localparam logic [31:0] INST_VSUB_VX   = 32'h08004057;
    localparam logic [31:0] INST_VRSUB_VX  = 32'h0c004057;
    localparam logic [31:0] INST_VRSUB_VI  = 32'h0c003057;
    localparam logic [31:0] INST_VMINU_VV  = 32'h10000057;
    localparam logic [31:0] INST_VMINU_VX  = 32'h10004057;
    localparam logic [31:0] INST_VMAXU_VV  = 32'h18000057;
    localparam logic [31:0] INST_VMAXU_VX  = 32'h18004057;

    // Instruction field LSB positions (all index fields are 5 bits wide).
    localparam int V_VD_LSB  = 7;
    localparam int V_VS1_LSB = 15;
    localparam int V_VS2_LSB = 20;

    // One buffered instruction as it travels through the FIFO.
    typedef struct packed {
        logic [31:0] opcode;
        logic [31:0] pc;
        logic [31:0] ra_operand;
        logic [31:0] rb_operand;
    } issue_entry_t;

    function automatic logic is_supported_vop(input logic [31:0] op);
        logic [31:0] m;
        m = op & INST_V_MASK;
        return (m == INST_VADD_VV)  || (m == INST_VADD_VX)  || (m == INST_VADD_VI)  ||
               (m == INST_VSUB_VV)  || (m == INST_VSUB_VX)  ||
               (m == INST_VRSUB_VX) || (m == INST_VRSUB_VI) ||
               (m == INST_VMINU_VV) || (m == INST_VMINU_VX) ||
               (m == INST_VMAXU_VV) || (m == INST_VMAXU_VX);
    endfunction

endpackage

// File: rtl/biriscv_v_issue_fifo.sv
// -----------------------------------------------------------------------------
// biriscv_v_issue_fifo
// Synchronous FIFO with combinational head read.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/data_i: write request and data (ignored while full)
//   pop_i        : remove head (ignored while empty)
//   data_o       : current head entry
//   count_o      : occupancy; full_o / empty_o status flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module biriscv_v_issue_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/biriscv_v_issue.sv
// -----------------------------------------------------------------------------
// biriscv_v_issue
// Issue side of the vector ALU: buffers decoded vector instructions, reads
// vs2/vs1/v0 from the VRF (R), drives the registered request bundle to the
// exec unit (EX), captures its combinational result and writes the VRF (WB).
// Results still in EX or WB are forwarded back into R (EX has priority).
//   issue_*      : instruction input with valid/accept handshake
//   vrf_*        : two combinational read ports, v0 mask, one write port
//   opcode_*     : registered request bundle to the exec unit
//   writeback_*  : exec result, same cycle as opcode_valid_o
//   fault_*      : pulse + held PC when an unsupported opcode retires
//   busy_o       : anything buffered or in flight
// -----------------------------------------------------------------------------
module biriscv_v_issue
    import biriscv_v_issue_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int ELEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    output logic            issue_accept_o,
    input  logic [31:0]     issue_opcode_i,
    input  logic [31:0]     issue_pc_i,
    input  logic [31:0]     issue_ra_operand_i,
    input  logic [31:0]     issue_rb_operand_i,
    output logic [4:0]      vrf_ra_idx_o,
    input  logic [VLEN-1:0] vrf_ra_data_i,
    output logic [4:0]      vrf_rb_idx_o,
    input  logic [VLEN-1:0] vrf_rb_data_i,
    input  logic [VLEN-1:0] vrf_mask_data_i,
    output logic            vrf_wr_en_o,
    output logic [4:0]      vrf_wr_idx_o,
    output logic [VLEN-1:0] vrf_wr_data_o,
    output logic            opcode_valid_o,
    output logic [31:0]     opcode_opcode_o,
    output logic [31:0]     opcode_pc_o,
    output logic            opcode_invalid_o,
    output logic [4:0]      opcode_rd_idx_o,
    output logic [4:0]      opcode_vd_idx_o,
    output logic [4:0]      opcode_ra_idx_o,
    output logic [4:0]      opcode_rb_idx_o,
    output logic [4:0]      opcode_va_idx_o,
    output logic [4:0]      opcode_vb_idx_o,
    output logic [31:0]     opcode_ra_operand_o,
    output logic [31:0]     opcode_rb_operand_o,
    output logic [VLEN-1:0] opcode_va_operand_o,
    output logic [VLEN-1:0] opcode_vb_operand_o,
    output logic [VLEN-1:0] opcode_vmask_operand_o,
    input  logic            writeback_valid_i,
    input  logic [VLEN-1:0] writeback_value_i,
    output logic            fault_o,
    output logic [31:0]     fault_pc_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (VLEN % ELEN != 0) begin : g_bad_elen
        $error("VLEN must be a multiple of ELEN");
    end

    // ---------------- instruction buffer / R stage ----------------
    issue_entry_t     push_entry, head;
    logic             fifo_full, fifo_empty, r_valid;
    logic [CNT_W-1:0] fifo_count;
    logic [4:0]       r_vd, r_vs1, r_vs2;

    assign push_entry = '{opcode: issue_opcode_i, pc: issue_pc_i,
                          ra_operand: issue_ra_operand_i, rb_operand: issue_rb_operand_i};

    biriscv_v_issue_fifo #(
        .WIDTH ($bits(issue_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue_valid_i),
        .data_i  (push_entry),
        .pop_i   (r_valid),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign issue_accept_o = ~fifo_full;
    // Nothing downstream ever stalls, so the head leaves R every cycle it exists.
    assign r_valid = ~fifo_empty;

    assign r_vd  = head.opcode[V_VD_LSB  +: 5];
    assign r_vs1 = head.opcode[V_VS1_LSB +: 5];
    assign r_vs2 = head.opcode[V_VS2_LSB +: 5];

    // Indices are parked at 0 while the buffer is empty so stale storage never shows.
    assign vrf_ra_idx_o = r_valid ? r_vs2 : 5'd0;
    assign vrf_rb_idx_o = r_valid ? r_vs1 : 5'd0;

    // ---------------- pipeline state ----------------
    logic            ex_valid_q, ex_valid_d, ex_invalid_q, ex_invalid_d;
    logic [31:0]     ex_opcode_q, ex_opcode_d, ex_pc_q, ex_pc_d;
    logic [4:0]      ex_vd_q, ex_vd_d, ex_vs1_q, ex_vs1_d, ex_vs2_q, ex_vs2_d;
    logic [31:0]     ex_ra_q, ex_ra_d, ex_rb_q, ex_rb_d;
    logic [VLEN-1:0] ex_va_q, ex_va_d, ex_vb_q, ex_vb_d, ex_vm_q, ex_vm_d;
    logic            wb_valid_q, wb_valid_d, wb_invalid_q, wb_invalid_d;
    logic [4:0]      wb_vd_q, wb_vd_d;
    logic [VLEN-1:0] wb_data_q, wb_data_d;
    logic [31:0]     fault_pc_q, fault_pc_d;
    logic            ex_fwd_ok, wb_fwd_ok;

    assign ex_fwd_ok = ex_valid_q & ~ex_invalid_q;
    assign wb_fwd_ok = wb_valid_q & ~wb_invalid_q;

    // Youngest producer wins: EX result (live from the exec unit), then WB, then VRF.
    function automatic logic [VLEN-1:0] fwd_sel(
        input logic [4:0] idx, input logic [VLEN-1:0] vrf_val,
        input logic ex_ok, input logic [4:0] ex_vd, input logic [VLEN-1:0] ex_val,
        input logic wb_ok, input logic [4:0] wb_vd, input logic [VLEN-1:0] wb_val);
        if (ex_ok && ex_vd == idx) return ex_val;
        if (wb_ok && wb_vd == idx) return wb_val;
        return vrf_val;
    endfunction

    always_comb begin
        ex_valid_d   = r_valid;
        ex_invalid_d = ex_invalid_q;
        ex_opcode_d  = ex_opcode_q;
        ex_pc_d      = ex_pc_q;
        ex_vd_d      = ex_vd_q;
        ex_vs1_d     = ex_vs1_q;
        ex_vs2_d     = ex_vs2_q;
        ex_ra_d      = ex_ra_q;
        ex_rb_d      = ex_rb_q;
        ex_va_d      = ex_va_q;
        ex_vb_d      = ex_vb_q;
        ex_vm_d      = ex_vm_q;
        if (r_valid) begin
            ex_invalid_d = ~is_supported_vop(head.opcode);
            ex_opcode_d  = head.opcode;
            ex_pc_d      = head.pc;
            ex_vd_d      = r_vd;
            ex_vs1_d     = r_vs1;
            ex_vs2_d     = r_vs2;
            ex_ra_d      = head.ra_operand;
            ex_rb_d      = head.rb_operand;
            ex_va_d      = fwd_sel(r_vs2, vrf_ra_data_i, ex_fwd_ok, ex_vd_q, writeback_value_i,
                                   wb_fwd_ok, wb_vd_q, wb_data_q);
            ex_vb_d      = fwd_sel(r_vs1, vrf_rb_data_i, ex_fwd_ok, ex_vd_q, writeback_value_i,
                                   wb_fwd_ok, wb_vd_q, wb_data_q);
            ex_vm_d      = fwd_sel(5'd0, vrf_mask_data_i, ex_fwd_ok, ex_vd_q, writeback_value_i,
                                   wb_fwd_ok, wb_vd_q, wb_data_q);
        end

        // A missing exec result turns the instruction into a fault rather than a write.
        wb_valid_d   = ex_valid_q;
        wb_invalid_d = ex_invalid_q | ~writeback_valid_i;
        wb_vd_d      = ex_vd_q;
        wb_data_d    = (ex_valid_q & writeback_valid_i) ? writeback_value_i : wb_data_q;
        fault_pc_d   = (ex_valid_q & wb_invalid_d) ? ex_pc_q : fault_pc_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q   <= 1'b0;
            ex_invalid_q <= 1'b0;
            ex_opcode_q  <= '0;
            ex_pc_q      <= '0;
            ex_vd_q      <= '0;
            ex_vs1_q     <= '0;
            ex_vs2_q     <= '0;
            ex_ra_q      <= '0;
            ex_rb_q      <= '0;
            ex_va_q      <= '0;
            ex_vb_q      <= '0;
            ex_vm_q      <= '0;
            wb_valid_q   <= 1'b0;
            wb_invalid_q <= 1'b0;
            wb_vd_q      <= '0;
            wb_data_q    <= '0;
            fault_pc_q   <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_invalid_q <= ex_invalid_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_pc_q      <= ex_pc_d;
            ex_vd_q      <= ex_vd_d;
            ex_vs1_q     <= ex_vs1_d;
            ex_vs2_q     <= ex_vs2_d;
            ex_ra_q      <= ex_ra_d;
            ex_rb_q      <= ex_rb_d;
            ex_va_q      <= ex_va_d;
            ex_vb_q      <= ex_vb_d;
            ex_vm_q      <= ex_vm_d;
            wb_valid_q   <= wb_valid_d;
            wb_invalid_q <= wb_invalid_d;
            wb_vd_q      <= wb_vd_d;
            wb_data_q    <= wb_data_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

    // ---------------- outputs ----------------
    assign opcode_valid_o         = ex_valid_q;
    assign opcode_opcode_o        = ex_opcode_q;
    assign opcode_pc_o            = ex_pc_q;
    assign opcode_invalid_o       = ex_invalid_q;
    assign opcode_rd_idx_o        = ex_vd_q;
    assign opcode_vd_idx_o        = ex_vd_q;
    assign opcode_ra_idx_o        = ex_vs1_q;
    assign opcode_rb_idx_o        = ex_vs2_q;
    assign opcode_va_idx_o        = ex_vs2_q;
    assign opcode_vb_idx_o        = ex_vs1_q;
    assign opcode_ra_operand_o    = ex_ra_q;
    assign opcode_rb_operand_o    = ex_rb_q;
    assign opcode_va_operand_o    = ex_va_q;
    assign opcode_vb_operand_o    = ex_vb_q;
    assign opcode_vmask_operand_o = ex_vm_q;

    assign vrf_wr_en_o   = wb_fwd_ok;
    assign vrf_wr_idx_o  = wb_vd_q;
    assign vrf_wr_data_o = wb_data_q;
    assign fault_o       = wb_valid_q & wb_invalid_q;
    assign fault_pc_o    = fault_pc_q;
    assign busy_o        = (fifo_count != '0) | ex_valid_q | wb_valid_q;

endmodule

// File: tb/tb_biriscv_v_issue.sv
// -----------------------------------------------------------------------------
// tb_biriscv_v_issue
// Directed bench for biriscv_v_issue: a behavioural VRF and a small vector ALU
// stand in for the neighbours; each scenario task checks hand-computed values.
// -----------------------------------------------------------------------------
module tb_biriscv_v_issue;

    localparam int VLEN = 128;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            issue_valid_i;
    logic            issue_accept_o;
    logic [31:0]     issue_opcode_i, issue_pc_i, issue_ra_operand_i, issue_rb_operand_i;
    logic [4:0]      vrf_ra_idx_o, vrf_rb_idx_o, vrf_wr_idx_o;
    logic [VLEN-1:0] vrf_ra_data_i, vrf_rb_data_i, vrf_mask_data_i, vrf_wr_data_o;
    logic            vrf_wr_en_o;
    logic            opcode_valid_o, opcode_invalid_o;
    logic [31:0]     opcode_opcode_o, opcode_pc_o, opcode_ra_operand_o, opcode_rb_operand_o;
    logic [4:0]      opcode_rd_idx_o, opcode_vd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o;
    logic [4:0]      opcode_va_idx_o, opcode_vb_idx_o;
    logic [VLEN-1:0] opcode_va_operand_o, opcode_vb_operand_o, opcode_vmask_operand_o;
    logic            writeback_valid_i;
    logic [VLEN-1:0] writeback_value_i;
    logic            fault_o, busy_o;
    logic [31:0]     fault_pc_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [VLEN-1:0] vrf [32];
    logic [4:0]      log_idx [$];
    logic [VLEN-1:0] log_data [$];
    int              log_cyc [$];

    always #5 clk_i = ~clk_i;

    biriscv_v_issue #(.VLEN(VLEN), .ELEN(32), .FIFO_DEPTH(4)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .issue_valid_i          (issue_valid_i),
        .issue_accept_o         (issue_accept_o),
        .issue_opcode_i         (issue_opcode_i),
        .issue_pc_i             (issue_pc_i),
        .issue_ra_operand_i     (issue_ra_operand_i),
        .issue_rb_operand_i     (issue_rb_operand_i),
        .vrf_ra_idx_o           (vrf_ra_idx_o),
        .vrf_ra_data_i          (vrf_ra_data_i),
        .vrf_rb_idx_o           (vrf_rb_idx_o),
        .vrf_rb_data_i          (vrf_rb_data_i),
        .vrf_mask_data_i        (vrf_mask_data_i),
        .vrf_wr_en_o            (vrf_wr_en_o),
        .vrf_wr_idx_o           (vrf_wr_idx_o),
        .vrf_wr_data_o          (vrf_wr_data_o),
        .opcode_valid_o         (opcode_valid_o),
        .opcode_opcode_o        (opcode_opcode_o),
        .opcode_pc_o            (opcode_pc_o),
        .opcode_invalid_o       (opcode_invalid_o),
        .opcode_rd_idx_o        (opcode_rd_idx_o),
        .opcode_vd_idx_o        (opcode_vd_idx_o),
        .opcode_ra_idx_o        (opcode_ra_idx_o),
        .opcode_rb_idx_o        (opcode_rb_idx_o),
        .opcode_va_idx_o        (opcode_va_idx_o),
        .opcode_vb_idx_o        (opcode_vb_idx_o),
        .opcode_ra_operand_o    (opcode_ra_operand_o),
        .opcode_rb_operand_o    (opcode_rb_operand_o),
        .opcode_va_operand_o    (opcode_va_operand_o),
        .opcode_vb_operand_o    (opcode_vb_operand_o),
        .opcode_vmask_operand_o (opcode_vmask_operand_o),
        .writeback_valid_i      (writeback_valid_i),
        .writeback_value_i      (writeback_value_i),
        .fault_o                (fault_o),
        .fault_pc_o             (fault_pc_o),
        .busy_o                 (busy_o)
    );

    // Behavioural VRF: combinational reads, writes logged with their cycle.
    assign vrf_ra_data_i   = vrf[vrf_ra_idx_o];
    assign vrf_rb_data_i   = vrf[vrf_rb_idx_o];
    assign vrf_mask_data_i = vrf[0];

    always @(posedge clk_i) begin
        if (vrf_wr_en_o) begin
            vrf[vrf_wr_idx_o] = vrf_wr_data_o;
            log_idx.push_back(vrf_wr_idx_o);
            log_data.push_back(vrf_wr_data_o);
            log_cyc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    // Exec-unit stand-in: 4 x 32-bit lanes, masked-off lanes produce 0.
    assign writeback_valid_i = opcode_valid_o & ~opcode_invalid_o;
    always_comb begin
        logic [31:0] a, b, r, imm;
        a = '0;
        b = '0;
        r = '0;
        writeback_value_i = '0;
        imm = {{27{opcode_opcode_o[19]}}, opcode_opcode_o[19:15]};
        for (int l = 0; l < 4; l++) begin
            a = opcode_va_operand_o[l*32 +: 32];
            case (opcode_opcode_o[14:12])
                3'b000:  b = opcode_vb_operand_o[l*32 +: 32];
                3'b100:  b = opcode_ra_operand_o;
                default: b = imm;
            endcase
            case (opcode_opcode_o[31:26])
                6'b000000: r = a + b;
                6'b000010: r = a - b;
                6'b000011: r = b - a;
                6'b000100: r = (a < b) ? a : b;
                6'b000110: r = (a > b) ? a : b;
                default:   r = '0;
            endcase
            if (!opcode_opcode_o[25] && !opcode_vmask_operand_o[l]) r = '0;
            writeback_value_i[l*32 +: 32] = r;
        end
    end

    function automatic logic [31:0] enc(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                        input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd);
        return {f6, vm, vs2, vs1, f3, vd, 7'h57};
    endfunction

    function automatic logic [VLEN-1:0] rep4(input logic [31:0] v);
        return {v, v, v, v};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    // Holds the instruction until accepted (bounded); returns 1 ns after the taking edge.
    task automatic push(input logic [31:0] op, input logic [31:0] pc);
        bit done;
        done = 1'b0;
        issue_valid_i      = 1'b1;
        issue_opcode_i     = op;
        issue_pc_i         = pc;
        issue_ra_operand_i = 32'h7;
        issue_rb_operand_i = 32'h0;
        for (int i = 0; i < 20 && !done; i++) begin
            done = issue_accept_o;
            step(1);
        end
        total_cnt++;
        if (!done) $display("FAIL push_accept: pc %h never accepted", pc);
        else pass_cnt++;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
    endtask

    task automatic wait_log(input int n, input string name);
        for (int i = 0; i < 40 && log_idx.size() < n; i++) step(1);
        total_cnt++;
        if (log_idx.size() < n) $display("FAIL %s_writes: got %0d writes, want %0d", name, log_idx.size(), n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle();
        step(2);
        total_cnt++; if (opcode_valid_o !== 1'b0) $display("FAIL rst_opcode_valid: got %b want 0", opcode_valid_o); else pass_cnt++;
        total_cnt++; if (vrf_wr_en_o !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", vrf_wr_en_o); else pass_cnt++;
        total_cnt++; if (fault_o !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault_o); else pass_cnt++;
        total_cnt++; if (fault_pc_o !== 32'h0) $display("FAIL rst_fault_pc: got %h want 0", fault_pc_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else pass_cnt++;
        total_cnt++; if (issue_accept_o !== 1'b1) $display("FAIL rst_accept: got %b want 1", issue_accept_o); else pass_cnt++;
        total_cnt++; if (opcode_va_operand_o !== '0) $display("FAIL rst_va: got %h want 0", opcode_va_operand_o); else pass_cnt++;
        rst_i = 1'b0;
        step(1);
    endtask

    task automatic test_single();
        vrf[2] = rep4(32'h1);
        vrf[3] = rep4(32'h1);
        clear_log();
        push(enc(6'b000000, 1'b1, 5'd2, 5'd3, 3'b000, 5'd1), 32'h40);
        idle();
        // N+1: head in R
        total_cnt++; if (vrf_ra_idx_o !== 5'd2) $display("FAIL single_ra_idx: got %0d want 2", vrf_ra_idx_o); else pass_cnt++;
        total_cnt++; if (vrf_rb_idx_o !== 5'd3) $display("FAIL single_rb_idx: got %0d want 3", vrf_rb_idx_o); else pass_cnt++;
        total_cnt++; if (opcode_valid_o !== 1'b0) $display("FAIL single_early_valid: got %b want 0", opcode_valid_o); else pass_cnt++;
        step(1);
        // N+2: EX
        total_cnt++; if (opcode_valid_o !== 1'b1) $display("FAIL single_valid: got %b want 1", opcode_valid_o); else pass_cnt++;
        total_cnt++; if (opcode_invalid_o !== 1'b0) $display("FAIL single_invalid: got %b want 0", opcode_invalid_o); else pass_cnt++;
        total_cnt++; if (opcode_vd_idx_o !== 5'd1) $display("FAIL single_vd: got %0d want 1", opcode_vd_idx_o); else pass_cnt++;
        total_cnt++; if (opcode_va_operand_o !== rep4(32'h1)) $display("FAIL single_va: got %h want %h", opcode_va_operand_o, rep4(32'h1)); else pass_cnt++;
        total_cnt++; if (vrf_wr_en_o !== 1'b0) $display("FAIL single_early_wr: got %b want 0", vrf_wr_en_o); else pass_cnt++;
        step(1);
        // N+3: WB
        total_cnt++; if (vrf_wr_en_o !== 1'b1) $display("FAIL single_wr_en: got %b want 1", vrf_wr_en_o); else pass_cnt++;
        total_cnt++; if (vrf_wr_idx_o !== 5'd1) $display("FAIL single_wr_idx: got %0d want 1", vrf_wr_idx_o); else pass_cnt++;
        total_cnt++; if (vrf_wr_data_o !== rep4(32'h2)) $display("FAIL single_wr_data: got %h want %h", vrf_wr_data_o, rep4(32'h2)); else pass_cnt++;
        step(1);
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL single_busy: got %b want 0", busy_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        vrf[2] = rep4(32'd5);
        clear_log();
        push(enc(6'b000000, 1'b1, 5'd2, 5'd3, 3'b011, 5'd1), 32'h50); // vadd.vi v1,v2,3
        push(enc(6'b000010, 1'b1, 5'd1, 5'd2, 3'b000, 5'd4), 32'h54); // vsub.vv v4,v1,v2
        idle();
        step(1);
        total_cnt++; if (opcode_va_operand_o !== rep4(32'd8)) $display("FAIL b2b_fwd_ex_va: got %h want %h", opcode_va_operand_o, rep4(32'd8)); else pass_cnt++;
        total_cnt++; if (opcode_vb_operand_o !== rep4(32'd5)) $display("FAIL b2b_vb: got %h want %h", opcode_vb_operand_o, rep4(32'd5)); else pass_cnt++;
        wait_log(2, "b2b");
        total_cnt++; if (log_idx[0] !== 5'd1 || log_data[0] !== rep4(32'd8)) $display("FAIL b2b_first: got v%0d=%h want v1=%h", log_idx[0], log_data[0], rep4(32'd8)); else pass_cnt++;
        total_cnt++; if (log_idx[1] !== 5'd4 || log_data[1] !== rep4(32'd3)) $display("FAIL b2b_second: got v%0d=%h want v4=%h", log_idx[1], log_data[1], rep4(32'd3)); else pass_cnt++;
    endtask

    task automatic test_distance2();
        clear_log();
        push(enc(6'b000000, 1'b1, 5'd2, 5'd1, 3'b011, 5'd5), 32'h60); // v5 = v2+1 = 6
        push(enc(6'b000000, 1'b1, 5'd2, 5'd2, 3'b011, 5'd6), 32'h64); // v6 = v2+2 = 7
        push(enc(6'b000000, 1'b1, 5'd5, 5'd2, 3'b000, 5'd7), 32'h68); // v7 = v5+v2 = 11
        idle();
        wait_log(3, "dist2");
        total_cnt++; if (log_idx[1] !== 5'd6 || log_data[1] !== rep4(32'd7)) $display("FAIL dist2_mid: got v%0d=%h want v6=%h", log_idx[1], log_data[1], rep4(32'd7)); else pass_cnt++;
        total_cnt++; if (log_idx[2] !== 5'd7 || log_data[2] !== rep4(32'd11)) $display("FAIL dist2_fwd_wb: got v%0d=%h want v7=%h", log_idx[2], log_data[2], rep4(32'd11)); else pass_cnt++;
        total_cnt++; if (log_cyc[2] - log_cyc[0] !== 2) $display("FAIL dist2_no_bubble: got span %0d want 2", log_cyc[2] - log_cyc[0]); else pass_cnt++;
    endtask

    task automatic test_masked();
        vrf[0] = '0;
        vrf[8] = {32'd0, 32'd0, 32'd0, 32'd5};
        clear_log();
        push(enc(6'b000000, 1'b1, 5'd8, 5'd0, 3'b011, 5'd0), 32'h70); // v0 = v8 + 0 -> lanes 0,2 active
        push(enc(6'b000000, 1'b0, 5'd2, 5'd2, 3'b000, 5'd9), 32'h74); // v9 = v2+v2 masked by v0
        idle();
        step(1);
        total_cnt++; if (opcode_vmask_operand_o !== 128'h5) $display("FAIL mask_fwd: got %h want %h", opcode_vmask_operand_o, 128'h5); else pass_cnt++;
        wait_log(2, "mask");
        total_cnt++; if (log_idx[0] !== 5'd0 || log_data[0] !== 128'h5) $display("FAIL mask_v0_write: got v%0d=%h want v0=5", log_idx[0], log_data[0]); else pass_cnt++;
        total_cnt++; if (log_idx[1] !== 5'd9 || log_data[1] !== 128'h00000000_0000000a_00000000_0000000a)
            $display("FAIL mask_result: got v%0d=%h want v9=%h", log_idx[1], log_data[1], 128'h00000000_0000000a_00000000_0000000a);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        clear_log();
        for (int k = 0; k < 6; k++)
            push(enc(6'b000000, 1'b1, 5'd2, 5'(k), 3'b011, 5'(10 + k)), 32'h80 + 32'(4 * k));
        idle();
        step(2);
        total_cnt++; if (busy_o !== 1'b1) $display("FAIL bp_busy_wb: got %b want 1", busy_o); else pass_cnt++;
        total_cnt++; if (vrf_wr_en_o !== 1'b1) $display("FAIL bp_last_wr: got %b want 1", vrf_wr_en_o); else pass_cnt++;
        step(1);
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL bp_busy_fall: got %b want 0", busy_o); else pass_cnt++;
        step(3);
        total_cnt++; if (log_idx.size() !== 6) $display("FAIL bp_count: got %0d writes want 6", log_idx.size()); else pass_cnt++;
        for (int k = 0; k < 6 && k < log_idx.size(); k++) begin
            total_cnt++;
            if (log_idx[k] !== 5'(10 + k) || log_data[k] !== rep4(32'(5 + k)))
                $display("FAIL bp_order%0d: got v%0d=%h want v%0d=%h", k, log_idx[k], log_data[k], 10 + k, rep4(32'(5 + k)));
            else pass_cnt++;
        end
        total_cnt++; if (log_cyc[5] - log_cyc[0] !== 5) $display("FAIL bp_throughput: got span %0d want 5", log_cyc[5] - log_cyc[0]); else pass_cnt++;
    endtask

    task automatic test_fault();
        clear_log();
        push(32'hfc000057, 32'h100);
        idle();
        step(1);
        total_cnt++; if (opcode_valid_o !== 1'b1 || opcode_invalid_o !== 1'b1) $display("FAIL fault_decode: got valid=%b invalid=%b want 1/1", opcode_valid_o, opcode_invalid_o); else pass_cnt++;
        step(1);
        total_cnt++; if (fault_o !== 1'b1) $display("FAIL fault_pulse: got %b want 1", fault_o); else pass_cnt++;
        total_cnt++; if (fault_pc_o !== 32'h100) $display("FAIL fault_pc: got %h want 100", fault_pc_o); else pass_cnt++;
        total_cnt++; if (vrf_wr_en_o !== 1'b0) $display("FAIL fault_no_wr: got %b want 0", vrf_wr_en_o); else pass_cnt++;
        step(1);
        total_cnt++; if (fault_o !== 1'b0) $display("FAIL fault_one_cycle: got %b want 0", fault_o); else pass_cnt++;
        total_cnt++; if (fault_pc_o !== 32'h100) $display("FAIL fault_pc_hold: got %h want 100", fault_pc_o); else pass_cnt++;
        total_cnt++; if (log_idx.size() !== 0) $display("FAIL fault_writes: got %0d writes want 0", log_idx.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        push(enc(6'b000000, 1'b1, 5'd2, 5'd1, 3'b011, 5'd20), 32'h200);
        push(enc(6'b000000, 1'b1, 5'd2, 5'd2, 3'b011, 5'd21), 32'h204);
        push(enc(6'b000000, 1'b1, 5'd2, 5'd3, 3'b011, 5'd22), 32'h208);
        idle();
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        clear_log();
        total_cnt++; if (vrf_wr_en_o !== 1'b0) $display("FAIL rstmid_wr_en: got %b want 0", vrf_wr_en_o); else pass_cnt++;
        total_cnt++; if (opcode_valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", opcode_valid_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_o); else pass_cnt++;
        total_cnt++; if (fault_pc_o !== 32'h0) $display("FAIL rstmid_fault_pc: got %h want 0", fault_pc_o); else pass_cnt++;
        total_cnt++; if (opcode_pc_o !== 32'h0 || opcode_va_operand_o !== '0) $display("FAIL rstmid_data: got pc=%h va=%h want 0", opcode_pc_o, opcode_va_operand_o); else pass_cnt++;
        step(4);
        total_cnt++; if (log_idx.size() !== 0) $display("FAIL rstmid_writes: got %0d writes want 0", log_idx.size()); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) vrf[i] = '0;
        rst_i              = 1'b1;
        issue_valid_i      = 1'b0;
        issue_opcode_i     = '0;
        issue_pc_i         = '0;
        issue_ra_operand_i = '0;
        issue_rb_operand_i = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_distance2();
        test_masked();
        test_backpressure();
        test_fault();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/biriscv_v_issue.md
Name: biriscv_v_issue

Overview:
Initiator side of the vector ALU exec interface. Buffers decoded vector instructions from the scalar pipeline and reads vs1, vs2 and v0 from the vector register file (VRF). Drives opcode and operands into the vector ALU exec unit, captures its combinational writeback and writes the VRF. It has three stages (R/EX/WB), with forwarding from EX and WB back to R.

Parameters:
VLEN, 128, vector register width in bits
ELEN, 32, element width in bits; VLEN/ELEN lanes
FIFO_DEPTH, 4, instruction buffer entries; power of 2, >=2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
issue_valid_i  in  1  instruction offered
issue_accept_o  out  1  instruction taken this cycle when valid&accept
issue_opcode_i  in  32  instruction word
issue_pc_i  in  32  instruction PC
issue_ra_operand_i  in  32  scalar rs1 value
issue_rb_operand_i  in  32  scalar rs2 value
vrf_ra_idx_o  out  5  VRF read port A index (vs2)
vrf_ra_data_i  in  VLEN  combinational read data A
vrf_rb_idx_o  out  5  VRF read port B index (vs1)
vrf_rb_data_i  in  VLEN  combinational read data B
vrf_mask_data_i  in  VLEN  v0 contents, always valid
vrf_wr_en_o  out  1  VRF write strobe
vrf_wr_idx_o  out  5  VRF write index
vrf_wr_data_o  out  VLEN  VRF write data
opcode_valid_o, opcode_opcode_o[32], opcode_pc_o[32], opcode_invalid_o, opcode_rd_idx_o[5], opcode_vd_idx_o[5], opcode_ra_idx_o[5], opcode_rb_idx_o[5], opcode_va_idx_o[5], opcode_vb_idx_o[5], opcode_ra_operand_o[32], opcode_rb_operand_o[32], opcode_va_operand_o[VLEN], opcode_vb_operand_o[VLEN], opcode_vmask_operand_o[VLEN]  out  exec-unit request bundle, all registered (EX stage)
writeback_valid_i  in  1  exec result valid (same cycle as opcode_valid_o)
writeback_value_i  in  VLEN  exec result
fault_o  out  1  one-cycle pulse: unsupported vector opcode retired
fault_pc_o  out  32  PC of faulting instruction, held until next fault
busy_o  out  1  FIFO non-empty or any stage valid

Behaviour:
- Reset: FIFO empty, count 0, all stage valids 0. Outputs opcode_valid_o=0, vrf_wr_en_o=0, fault_o=0, fault_pc_o=0, busy_o=0. All registered data outputs 0.
- Reset mid-operation: in-flight instructions are discarded and no VRF write occurs in the cycle after reset.
- FIFO:
  - issue_accept_o = !full.
  - Push on issue_valid_i & issue_accept_o; pop when R is valid (no stalls downstream).
  - Push and pop in the same cycle while full is not possible (accept=0).
  - Push and pop while non-full: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- R stage (FIFO head):
  - vd=[11:7], vb_idx=vs1=[19:15], va_idx=vs2=[24:20], rd_idx=[11:7], ra_idx=[19:15], rb_idx=[24:20].
  - vrf_ra_idx_o=vs2 and vrf_rb_idx_o=vs1, driven combinationally from the head.
- Forwarding into R for each of va, vb and mask (mask source index 0), priority EX > WB > VRF:
  - EX valid & !EX.invalid & EX.vd==idx: use writeback_value_i.
  - Otherwise WB valid & !WB.invalid & WB.vd==idx: use WB data.
- R->EX: every cycle; EX valid <= FIFO non-empty. opcode_invalid_o is set when the opcode matches none of: vadd.vv/vx/vi, vsub.vv/vx, vrsub.vx/vi, vminu.vv/vx, vmaxu.vv/vx (masks from biriscv_defs.v).
- EX->WB: capture writeback_value_i when opcode_valid_o & writeback_valid_i. If writeback_valid_i=0 while EX valid, WB carries invalid (no write, fault).
- WB stage:
  - vrf_wr_en_o = WB valid & !invalid.
  - Invalid instruction: fault_o=1 for one cycle, fault_pc_o<=pc, no VRF write.
- Latency: accept at cycle N, with FIFO empty beforehand:
  - N+1: R (head).
  - N+2: opcode_valid_o.
  - N+3: vrf_wr_en_o.
- Throughput is one instruction per cycle.
- Writes to v0 are ordinary; the v0 mask is forwarded like any other operand.

Decomposition:
- Shared package/defines (biriscv_defs.v): INST_V* match/mask constants, vector opcode field bit positions.
- Sub-module biriscv_v_issue_fifo: parameterised width/depth sync FIFO with count, full and empty.
- Forwarding and decode stay in the top module.

Test Plan:
- Single vadd.vv: v2=v3=4x32'h1, vm=1, vd=v1 -> opcode_valid_o at N+2; vrf_wr_en_o at N+3 with idx 1, data 4x32'h2.
- Back-to-back dependency: vadd.vi v1,v2,3 then vsub.vv v4,v1,v2 with v2=4x5 -> second instruction's va_operand forwarded from EX (4x8); v4=4x3.
- Distance-2 dependency with an independent instruction between -> WB forward used; correct value written, no bubble.
- Masked op vm=0: preceding write to v0=lane0,lane2 set -> forwarded mask; lanes 1,3 result 0.
- Backpressure: 6 pushes with no gaps into FIFO_DEPTH=4 -> all issue in order with no loss or duplication; busy_o falls 3 cycles after the last pop.
- Unsupported opcode 32'h0000_0057|funct6=6'b111111 at PC 0x100 -> opcode_invalid_o=1, no VRF write, fault_o pulse, fault_pc_o=0x100. Reset asserted mid-stream -> no write the next cycle, all outputs at reset values.
